// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares NUM_PORTS common-data-bus writeback slots among NUM_REQ completion
// sources (0=ALU, 1=branch, 2=LSU). Each source hands a finished result to a
// one-entry holding buffer through a valid/ready handshake. Held results are
// granted onto CDB slots in round-robin order and broadcast to the PRF write
// ports, ROB completion inputs and dispatch wakeup logic. Results younger than
// a mispredicted branch are dropped, both from the buffers and at the input.
//
// Optional build macro:
//   CDB_STARVE_OVERRIDE_EN - per-source wait counters; a source that has
//                            waited STARVE_LIMIT cycles takes slot 0 ahead of
//                            round-robin order (lowest index wins ties).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/ready per-source handshake
//   req_preg/data/rob per-source payload, source i at [i*W +: W]
//   rob_head        oldest in-flight ROB tag (reference point for age)
//   mispredict      one-cycle flush pulse, with mispredict_tag
//   cdb_valid       per-slot broadcast strobe
//   cdb_preg/data/rob per-slot broadcast payload, slot k at [k*W +: W]
//   cdb_src         per-slot granted source index (debug)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int NUM_PORTS    = 2,
    parameter int DATA_W       = 32,
    parameter int PREG_W       = 7,
    parameter int ROB_W        = 5,
    parameter int STARVE_LIMIT = 4,
    localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*PREG_W-1:0]   req_preg,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*ROB_W-1:0]    req_rob,
    input  logic [ROB_W-1:0]            rob_head,
    input  logic                        mispredict,
    input  logic [ROB_W-1:0]            mispredict_tag,
    output logic [NUM_PORTS-1:0]        cdb_valid,
    output logic [NUM_PORTS*PREG_W-1:0] cdb_preg,
    output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
    output logic [NUM_PORTS*ROB_W-1:0]  cdb_rob,
    output logic [NUM_PORTS*SRC_W-1:0]  cdb_src
);

    if (NUM_PORTS < 1 || NUM_PORTS > NUM_REQ || STARVE_LIMIT < 1) begin : g_bad_params
        $error("cdb_arbiter: NUM_PORTS must be 1..NUM_REQ and STARVE_LIMIT >= 1");
    end

    // Holding buffers and arbiter state
    logic [NUM_REQ-1:0] held_valid;
    logic [PREG_W-1:0]  held_preg [NUM_REQ];
    logic [DATA_W-1:0]  held_data [NUM_REQ];
    logic [ROB_W-1:0]   held_rob  [NUM_REQ];
    logic [SRC_W-1:0]   rr_ptr;

    // Per-cycle decisions
    logic [NUM_REQ-1:0]   kill;      // held entry is on the wrong path
    logic [NUM_REQ-1:0]   in_kill;   // incoming entry is on the wrong path
    logic [NUM_REQ-1:0]   granted;
    logic [NUM_REQ-1:0]   accept;
    logic [NUM_PORTS-1:0] slot_valid;
    logic [SRC_W-1:0]     slot_src [NUM_PORTS];
    logic                 any_grant;
    logic [SRC_W-1:0]     last_src;

    // Distance from the ROB head; the subtraction wraps in ROB_W bits, so a
    // larger value always means younger regardless of tag wrap-around.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                 input logic [ROB_W-1:0] head);
        return tag - head;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        kill    = '0;
        in_kill = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kill[i]    = mispredict && held_valid[i] &&
                         (rob_age(held_rob[i], rob_head) > rob_age(mispredict_tag, rob_head));
            in_kill[i] = mispredict &&
                         (rob_age(req_rob[i*ROB_W +: ROB_W], rob_head) >
                          rob_age(mispredict_tag, rob_head));
        end
    end

`ifdef CDB_STARVE_OVERRIDE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]   wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Counts cycles a live entry sits un-granted; saturates at the limit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || !held_valid[i] || granted[i] || kill[i]) begin
                wait_cnt[i] <= '0;
            end else if (!starved[i]) begin
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end
`endif

    // Grant: each eligible source's slot number is its rank in scan order
    // (distance from rr_ptr), offset by one when a starved source holds slot 0.
    always_comb begin
        int                 pos  [NUM_REQ];
        int                 rank [NUM_REQ];
        int                 best;
        logic [NUM_REQ-1:0] eligible;
        logic [NUM_REQ-1:0] starve_sel;

        eligible   = held_valid & ~kill & {NUM_REQ{~reset}};
        starve_sel = '0;
`ifdef CDB_STARVE_OVERRIDE_EN
        // Walk downward so the lowest starved index is the one left selected.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i] && starved[i]) begin
                starve_sel    = '0;
                starve_sel[i] = 1'b1;
            end
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            pos[i] = i - int'(rr_ptr);
            if (pos[i] < 0) pos[i] = pos[i] + NUM_REQ;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            rank[i] = 0;
            if (!starve_sel[i]) begin
                if (starve_sel != '0) rank[i] = 1;
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j != i && eligible[j] && !starve_sel[j] && pos[j] < pos[i]) begin
                        rank[i] = rank[i] + 1;
                    end
                end
            end
        end

        granted  = '0;
        best     = -1;
        last_src = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i] && rank[i] < NUM_PORTS) begin
                granted[i] = 1'b1;
                if (rank[i] > best) begin
                    best     = rank[i];
                    last_src = SRC_W'(i);
                end
            end
        end
        any_grant = |granted;

        slot_valid = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            slot_src[k] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted[i] && rank[i] == k) begin
                    slot_valid[k] = 1'b1;
                    slot_src[k]   = SRC_W'(i);
                end
            end
        end
    end

    // Broadcast and handshake outputs
    always_comb begin
        cdb_valid = slot_valid;
        cdb_preg  = '0;
        cdb_data  = '0;
        cdb_rob   = '0;
        cdb_src   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (slot_valid[k]) begin
                cdb_preg[k*PREG_W +: PREG_W] = held_preg[slot_src[k]];
                cdb_data[k*DATA_W +: DATA_W] = held_data[slot_src[k]];
                cdb_rob[k*ROB_W +: ROB_W]    = held_rob[slot_src[k]];
                cdb_src[k*SRC_W +: SRC_W]    = slot_src[k];
            end
        end
        // A buffer being drained this cycle can take a new entry at the same edge.
        req_ready = reset ? '1 : (~held_valid | granted);
        accept    = req_valid & req_ready & {NUM_REQ{~reset}};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    // A wrong-path arrival is consumed but not kept.
                    held_valid[i] <= !in_kill[i];
                end else if (granted[i] || kill[i]) begin
                    held_valid[i] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= (int'(last_src) == NUM_REQ - 1) ? '0 : last_src + 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; held_valid alone qualifies them
    // and the outputs are masked to zero whenever a slot is unused.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i] && !in_kill[i]) begin
                held_preg[i] <= req_preg[i*PREG_W +: PREG_W];
                held_data[i] <= req_data[i*DATA_W +: DATA_W];
                held_rob[i]  <= req_rob[i*ROB_W +: ROB_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter (default build, NUM_PORTS=2).
// Phase 1 applies a table of directed cycles covering reset, the three-way
// contention case, ALU streaming, mispredict kill at the outputs and input,
// mid-operation reset and back-to-back buffer replacement.
// Phase 2 drives random traffic against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int NUM_PORTS = 2;
    localparam int DATA_W    = 32;
    localparam int PREG_W    = 7;
    localparam int ROB_W     = 5;
    localparam int SRC_W     = 2;
    localparam int ROB_MOD   = 1 << ROB_W;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*PREG_W-1:0]   req_preg = '0;
    logic [NUM_REQ*DATA_W-1:0]   req_data = '0;
    logic [NUM_REQ*ROB_W-1:0]    req_rob = '0;
    logic [ROB_W-1:0]            rob_head = '0;
    logic                        mispredict = 1'b0;
    logic [ROB_W-1:0]            mispredict_tag = '0;
    logic [NUM_PORTS-1:0]        cdb_valid;
    logic [NUM_PORTS*PREG_W-1:0] cdb_preg;
    logic [NUM_PORTS*DATA_W-1:0] cdb_data;
    logic [NUM_PORTS*ROB_W-1:0]  cdb_rob;
    logic [NUM_PORTS*SRC_W-1:0]  cdb_src;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W),
        .PREG_W(PREG_W), .ROB_W(ROB_W), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_preg(req_preg), .req_data(req_data), .req_rob(req_rob),
        .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
        .cdb_rob(cdb_rob), .cdb_src(cdb_src)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-source payload the bench drives; also the source of model contents.
    logic [PREG_W-1:0] d_preg [NUM_REQ];
    logic [DATA_W-1:0] d_data [NUM_REQ];
    logic [ROB_W-1:0]  d_rob  [NUM_REQ];

    task automatic drive(input logic rst, input logic [NUM_REQ-1:0] vld,
                         input logic [ROB_W-1:0] head, input logic mp,
                         input logic [ROB_W-1:0] tag);
        reset          = rst;
        req_valid      = vld;
        rob_head       = head;
        mispredict     = mp;
        mispredict_tag = tag;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_preg[i*PREG_W +: PREG_W] = d_preg[i];
            req_data[i*DATA_W +: DATA_W] = d_data[i];
            req_rob[i*ROB_W +: ROB_W]    = d_rob[i];
        end
    endtask

    // Slot k as {src, preg, data}, zero-extended
    function automatic logic [63:0] slot_spd(input int k);
        return {23'd0, cdb_src[k*SRC_W +: SRC_W], cdb_preg[k*PREG_W +: PREG_W],
                cdb_data[k*DATA_W +: DATA_W]};
    endfunction

    function automatic logic [63:0] pack_spd(input logic [SRC_W-1:0] s,
                                             input logic [PREG_W-1:0] p,
                                             input logic [DATA_W-1:0] d);
        return {23'd0, s, p, d};
    endfunction

    function automatic int age(input int t, input int h);
        return ((t - h) % ROB_MOD + ROB_MOD) % ROB_MOD;
    endfunction

    function automatic logic [DATA_W-1:0] tbl_data(input int p);
        return 32'hC0DE_0000 | DATA_W'(p);
    endfunction

    // Directed vector: inputs for one cycle and the outputs expected in it
    typedef struct {
        bit       rst;
        bit [2:0] vld;
        int       p0, p1, p2;
        int       r0, r1, r2;
        int       head;
        bit       mp;
        int       tag;
        bit [1:0] ev;
        int       es0, ep0, es1, ep1;
        bit [2:0] erdy;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    bit                m_vld  [NUM_REQ];
    logic [PREG_W-1:0] m_preg [NUM_REQ];
    logic [DATA_W-1:0] m_data [NUM_REQ];
    logic [ROB_W-1:0]  m_rob  [NUM_REQ];
    int                m_rr;
    int                gl[$];
    bit                gnt [NUM_REQ];
    bit                kl  [NUM_REQ];

    initial begin
        vec_t             v;
        bit               rst, mp;
        logic [2:0]       vld, erdy;
        logic [1:0]       ev;
        logic [ROB_W-1:0] head, tag;
        logic [63:0]      exp_slot;
        int               idx;

        for (int i = 0; i < NUM_REQ; i++) begin
            d_preg[i] = '0; d_data[i] = '0; d_rob[i] = '0;
        end

        //            rst vld     p0  p1  p2  r0  r1  r2 head mp tag  ev    es0 ep0 es1 ep1 erdy
        vecs.push_back('{1, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        // Three-way contention
        vecs.push_back('{0, 3'b111, 10, 11, 12,  1,  2,  3,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b11, 0, 10, 1, 11, 3'b011});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b01, 2, 12, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        // ALU streaming, latency 1
        vecs.push_back('{0, 3'b001, 20,  0,  0,  5,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b001, 21,  0,  0,  6,  0,  0,  0, 0, 0, 2'b01, 0, 20, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b001, 22,  0,  0,  7,  0,  0,  0, 0, 0, 2'b01, 0, 21, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b01, 0, 22, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        // Mispredict: head 30, held tags 31/2/4, branch tag 2 -> tag 4 dropped
        vecs.push_back('{0, 3'b111, 40, 41, 42, 31,  2,  4, 30, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0, 30, 1, 2, 2'b11, 1, 41, 0, 40, 3'b011});
        // Incoming during mispredict: tag 1 kept, tag 5 discarded
        vecs.push_back('{0, 3'b101, 44,  0, 43,  1,  0,  5, 30, 1, 2, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0, 30, 0, 0, 2'b01, 0, 44, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0, 30, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        // Reset while three entries are held
        vecs.push_back('{0, 3'b111, 50, 51, 52,  7,  8,  9,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{1, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        // Back-to-back replacement of granted buffers
        vecs.push_back('{0, 3'b111, 60, 61, 62, 10, 11, 12,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b111, 63, 64, 65, 13, 14, 15,  0, 0, 0, 2'b11, 0, 60, 1, 61, 3'b011});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b11, 2, 62, 0, 63, 3'b101});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b01, 1, 64, 0,  0, 3'b111});
        vecs.push_back('{0, 3'b000,  0,  0,  0,  0,  0,  0,  0, 0, 0, 2'b00, 0,  0, 0,  0, 3'b111});

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            d_preg[0] = PREG_W'(v.p0); d_preg[1] = PREG_W'(v.p1); d_preg[2] = PREG_W'(v.p2);
            d_rob[0]  = ROB_W'(v.r0);  d_rob[1]  = ROB_W'(v.r1);  d_rob[2]  = ROB_W'(v.r2);
            for (int i = 0; i < NUM_REQ; i++) d_data[i] = tbl_data(int'(d_preg[i]));
            @(negedge clk);
            drive(v.rst, v.vld, ROB_W'(v.head), v.mp, ROB_W'(v.tag));
            #1;
            check($sformatf("vec%0d cdb_valid", r), 64'(cdb_valid), 64'(v.ev));
            check($sformatf("vec%0d req_ready", r), 64'(req_ready), 64'(v.erdy));
            check($sformatf("vec%0d slot0", r), slot_spd(0),
                  v.ev[0] ? pack_spd(SRC_W'(v.es0), PREG_W'(v.ep0), tbl_data(v.ep0)) : 64'd0);
            check($sformatf("vec%0d slot1", r), slot_spd(1),
                  v.ev[1] ? pack_spd(SRC_W'(v.es1), PREG_W'(v.ep1), tbl_data(v.ep1)) : 64'd0);
        end

        // Random traffic against the reference model; cycle 0 is a reset.
        for (int i = 0; i < NUM_REQ; i++) m_vld[i] = 1'b0;
        m_rr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc == 0) || ($urandom_range(99) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                vld[i]    = ($urandom_range(9) < 6);
                d_preg[i] = PREG_W'($urandom_range(127));
                d_data[i] = $urandom;
                d_rob[i]  = ROB_W'($urandom_range(ROB_MOD - 1));
            end
            head = ROB_W'($urandom_range(ROB_MOD - 1));
            tag  = ROB_W'($urandom_range(ROB_MOD - 1));
            mp   = ($urandom_range(5) == 0);
            @(negedge clk);
            drive(rst, vld, head, mp, tag);
            #1;

            // Expected grants: scan from the pointer, first NUM_PORTS live entries
            gl.delete();
            for (int i = 0; i < NUM_REQ; i++) begin
                kl[i]  = mp && m_vld[i] && (age(int'(m_rob[i]), int'(head)) > age(int'(tag), int'(head)));
                gnt[i] = 1'b0;
            end
            if (!rst) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_rr + k) % NUM_REQ;
                    if (m_vld[idx] && !kl[idx] && gl.size() < NUM_PORTS) gl.push_back(idx);
                end
            end
            foreach (gl[j]) gnt[gl[j]] = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) erdy[i] = rst || !m_vld[i] || gnt[i];
            for (int k = 0; k < NUM_PORTS; k++) ev[k] = (k < gl.size());

            check($sformatf("rand%0d cdb_valid", cyc), 64'(cdb_valid), 64'(ev));
            check($sformatf("rand%0d req_ready", cyc), 64'(req_ready), 64'(erdy));
            for (int k = 0; k < NUM_PORTS; k++) begin
                exp_slot = 64'd0;
                if (k < gl.size()) exp_slot = pack_spd(SRC_W'(gl[k]), m_preg[gl[k]], m_data[gl[k]]);
                check($sformatf("rand%0d slot%0d", cyc, k), slot_spd(k), exp_slot);
                check($sformatf("rand%0d slot%0d rob", cyc, k), 64'(cdb_rob[k*ROB_W +: ROB_W]),
                      (k < gl.size()) ? 64'(m_rob[gl[k]]) : 64'd0);
            end

            // Advance the model to the state after the coming edge
            if (rst) begin
                for (int i = 0; i < NUM_REQ; i++) m_vld[i] = 1'b0;
                m_rr = 0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (vld[i] && erdy[i]) begin
                        if (mp && age(int'(d_rob[i]), int'(head)) > age(int'(tag), int'(head))) begin
                            m_vld[i] = 1'b0;
                        end else begin
                            m_vld[i]  = 1'b1;
                            m_preg[i] = d_preg[i];
                            m_data[i] = d_data[i];
                            m_rob[i]  = d_rob[i];
                        end
                    end else if (gnt[i] || kl[i]) begin
                        m_vld[i] = 1'b0;
                    end
                end
                if (gl.size() > 0) m_rr = (gl[gl.size() - 1] + 1) % NUM_REQ;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares a small number of common data bus (CDB) writeback slots among the functional-unit completion sources (ALU, branch, LSU).
- Each source hands over a completed result (destination preg, data, ROB tag) through a valid/ready handshake. The result is held in a one-entry per-source buffer and granted onto a CDB slot with round-robin fairness.
- CDB slot outputs drive the PRF write ports, the ROB completion inputs and the dispatch wakeup inputs.
- Wrong-path results are killed on branch mispredict.

Parameters:
- NUM_REQ, 3, number of completion sources (index 0=ALU, 1=branch, 2=LSU)
- NUM_PORTS, 2, CDB slots broadcast per cycle; legal range 1..NUM_REQ
- DATA_W, 32, result data width
- PREG_W, 7, physical register tag width
- ROB_W, 5, ROB tag width
- STARVE_LIMIT, 4, wait cycles before starvation override (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  source i offers a result
- req_ready  out  NUM_REQ  source i's buffer can accept this cycle
- req_preg  in  NUM_REQ*PREG_W  destination preg per source, packed with source i at bits [i*PREG_W +: PREG_W]
- req_data  in  NUM_REQ*DATA_W  result data per source, packed the same way
- req_rob  in  NUM_REQ*ROB_W  ROB tag per source, packed the same way
- rob_head  in  ROB_W  oldest in-flight ROB tag
- mispredict  in  1  one-cycle flush pulse
- mispredict_tag  in  ROB_W  ROB tag of the mispredicted branch
- cdb_valid  out  NUM_PORTS  slot k broadcasts this cycle
- cdb_preg  out  NUM_PORTS*PREG_W  broadcast preg per slot
- cdb_data  out  NUM_PORTS*DATA_W  broadcast data per slot
- cdb_rob  out  NUM_PORTS*ROB_W  broadcast ROB tag per slot
- cdb_src  out  NUM_PORTS*$clog2(NUM_REQ)  granted source index per slot (debug)

Behaviour:
- State per source: held_valid, held_preg, held_data, held_rob. Arbiter state: rr_ptr, of width $clog2(NUM_REQ).
- Reset: all held_valid=0, rr_ptr=0. Outputs during reset cycle and after: cdb_valid=0, cdb_preg/cdb_data/cdb_rob/cdb_src=0, req_ready=all 1s.
- Grant (combinational, from held registers only):
  - Scan sources starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first NUM_PORTS sources with held_valid=1 and not killed receive slots 0..NUM_PORTS-1, in scan order.
- cdb_* outputs come combinationally from the granted held registers. Unused slots: cdb_valid=0, other fields 0.
- req_ready[i] = !held_valid[i] || granted[i]. It has no dependency on req_valid.
- Accept: a source's entry is accepted on the edge where req_valid[i] && req_ready[i].
  - The entry is written into the held register.
  - An entry accepted at edge N is broadcast no earlier than the cycle after edge N. Minimum latency is 1 cycle.
- Granted entry with no new accept: held_valid clears at the edge.
- Granted entry with a simultaneous accept: the new entry replaces it at the same edge (back-to-back throughput of 1 per source per cycle).
- rr_ptr update: if any grant occurs, rr_ptr <= (index of last granted source + 1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- Age compare: age(t) = (t - rob_head) mod 2^ROB_W. An entry is "younger" when age(held_rob) > age(mispredict_tag). Equal tag means the branch itself; it is never killed.
- Mispredict cycle:
  - Younger held entries are killed: not granted and not broadcast, and held_valid clears at the edge.
  - Older entries are granted normally.
  - Incoming requests that are younger, with req_ready high, are consumed and discarded, not stored.
  - rr_ptr updates from surviving grants only.
- Sources with no request and no held entry are skipped. All-idle cycle: cdb_valid=0.
- Stored data widths are fixed; no arithmetic beyond the modulo age subtraction, which wraps naturally in ROB_W bits.
- Reset asserted mid-operation: all held entries are discarded and nothing is broadcast that cycle.

Optional Feature:
- Macro CDB_STARVE_OVERRIDE_EN.
- Defined:
  - Per-source wait counter, saturating at STARVE_LIMIT.
  - The counter increments each cycle held_valid && !granted, and clears on grant, on kill or on reset.
  - A source whose counter equals STARVE_LIMIT is granted slot 0 ahead of round-robin order. Ties go to the lowest index.
  - Remaining slots are filled round-robin from rr_ptr, skipping the already-granted source.
- Undefined: no counters exist; arbitration is pure round-robin as above.

Test Plan:
- Reset, then idle -> cdb_valid=00, req_ready=111, rr_ptr=0.
- All three sources valid at edge 0 (ROB 1,2,3; pregs 10,11,12), rr_ptr=0, NUM_PORTS=2 -> next cycle sources 0,1 broadcast, preg 10/11 on slots 0/1, rr_ptr=2. The following cycle source 2 (preg 12) broadcasts.
- ALU streams req_valid every cycle with others idle -> one broadcast per cycle, req_ready[0] stays 1, latency 1 cycle.
- rob_head=30; held ROB tags 31 (ALU), 2 (branch), 4 (LSU); mispredict with tag 2 -> broadcasts 31 and 2, tag 4 is dropped and never appears on the CDB.
- Reset asserted while 3 entries are held -> that cycle cdb_valid=00, and after reset no stale preg is broadcast.
- With CDB_STARVE_OVERRIDE_EN, NUM_PORTS=1 and STARVE_LIMIT=2: sources 0 and 1 refilled every cycle while source 2 waits -> source 2 is granted within 3 cycles of being held. Without the macro, source 2 is granted at its round-robin turn.
